// File: rtl/rst_sequencer.sv
// rst_sequencer: holds domain resets, then releases them one by one,
// with software reset requests and a watchdog that restart the sequence.
module rst_sequencer #(
   parameter int NUM_CH         = 3,
   parameter int HOLD_CYCLES    = 16,
   parameter int STAGGER_CYCLES = 4,
   parameter int WDT_CYCLES     = 200,
   parameter int CNT_W          = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              swrst_req_i,
   output logic              swrst_ack_o,
   input  logic              wdt_en_i,
   input  logic              wdt_kick_i,
   output logic [NUM_CH-1:0] rst_o,
   output logic              ready_o,
   output logic [1:0]        cause_o
);

   localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int CNT_MAX = (CNT_W < 31) ? ((1 << CNT_W) - 1) : 32'h7fff_ffff;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);
   localparam logic [CNT_W-1:0] WDT_LAST  = CNT_W'(WDT_CYCLES - 1);
   localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NUM_CH - 1);

   localparam logic [1:0] CAUSE_EXT = 2'b00;
   localparam logic [1:0] CAUSE_SW  = 2'b01;
   localparam logic [1:0] CAUSE_WDT = 2'b10;

   // Elaboration-time parameter range checks (never synthesised).
   if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
      $error("rst_sequencer: NUM_CH must be 1..8");
   end
   if (CNT_W < 1 || CNT_W > 31) begin : g_bad_cnt_w
      $error("rst_sequencer: CNT_W must be 1..31");
   end
   if (HOLD_CYCLES < 1 || HOLD_CYCLES > CNT_MAX) begin : g_bad_hold
      $error("rst_sequencer: HOLD_CYCLES out of range");
   end
   if (STAGGER_CYCLES < 1 || STAGGER_CYCLES > CNT_MAX) begin : g_bad_stag
      $error("rst_sequencer: STAGGER_CYCLES out of range");
   end
   if (WDT_CYCLES < 2 || WDT_CYCLES > CNT_MAX) begin : g_bad_wdt
      $error("rst_sequencer: WDT_CYCLES out of range");
   end

   typedef enum logic [1:0] {
      HOLD,
      STAGGER,
      RUN
   } state_e;

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  wdt_q;
   logic [CNT_W-1:0]  wdt_d;
   logic              wdt_expire;
   logic [CH_W-1:0]   ch_q;
   logic [NUM_CH-1:0] rst_q;
   logic              ready_q;
   logic              ack_q;
   logic [1:0]        cause_q;

   // Watchdog: counts RUN cycles while enabled, kick or disable clears it.
   always_comb begin
      wdt_d      = '0;
      wdt_expire = 1'b0;
      if (state_q == RUN && wdt_en_i && !wdt_kick_i) begin
         if (wdt_q == WDT_LAST) begin
            wdt_expire = 1'b1;
         end else begin
            wdt_d = wdt_q + 1'b1;
         end
      end
   end

   // Sequencer FSM with registered outputs; external reset overrides all.
   always_ff @(posedge clk_i) begin
      ack_q <= 1'b0;
      if (rst_i) begin
         state_q <= HOLD;
         cnt_q   <= '0;
         ch_q    <= '0;
         wdt_q   <= '0;
         rst_q   <= '1;
         ready_q <= 1'b0;
         cause_q <= CAUSE_EXT;
      end else begin
         wdt_q <= wdt_d;
         unique case (state_q)
            HOLD: begin
               if (cnt_q == HOLD_LAST) begin
                  cnt_q    <= '0;
                  ch_q     <= CH_W'(1);
                  rst_q[0] <= 1'b0;
                  if (NUM_CH == 1) begin
                     state_q <= RUN;
                     ready_q <= 1'b1;
                  end else begin
                     state_q <= STAGGER;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            STAGGER: begin
               if (cnt_q == STAG_LAST) begin
                  cnt_q <= '0;
                  ch_q  <= ch_q + 1'b1;
                  for (int i = 0; i < NUM_CH; i++) begin
                     if (ch_q == CH_W'(i)) begin
                        rst_q[i] <= 1'b0;
                     end
                  end
                  if (ch_q == CH_LAST) begin
                     state_q <= RUN;
                     ready_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RUN: begin
               if (wdt_expire) begin
                  state_q <= HOLD;
                  cnt_q   <= '0;
                  rst_q   <= '1;
                  ready_q <= 1'b0;
                  cause_q <= CAUSE_WDT;
               end else if (swrst_req_i) begin
                  state_q <= HOLD;
                  cnt_q   <= '0;
                  rst_q   <= '1;
                  ready_q <= 1'b0;
                  cause_q <= CAUSE_SW;
                  ack_q   <= 1'b1;
               end
            end
            default: begin
               state_q <= HOLD;
               cnt_q   <= '0;
               rst_q   <= '1;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign swrst_ack_o = ack_q;
   assign rst_o       = rst_q;
   assign ready_o     = ready_q;
   assign cause_o     = cause_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// tb_rst_sequencer: directed stimulus on a 3-channel and a 1-channel
// build, checked every cycle against a timeline model plus literals.
module tb_rst_sequencer;

   localparam int HOLD = 16;
   localparam int STAG = 4;
   localparam int WDT  = 200;

   logic       clk;
   logic       rst;
   logic       req;
   logic       en;
   logic       kick;

   logic       ack0;
   logic [2:0] rsto0;
   logic       rdy0;
   logic [1:0] cause0;

   logic       ack1;
   logic [0:0] rsto1;
   logic       rdy1;
   logic [1:0] cause1;

   int vectors;
   int miscompares;
   int cyc;

   // Model: age = edges since the sequence (re)started; wd = watchdog run.
   int         age   [2];
   int         wd    [2];
   logic [1:0] mcause[2];
   logic       mack  [2];

   rst_sequencer dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .swrst_req_i(req),
      .swrst_ack_o(ack0),
      .wdt_en_i   (en),
      .wdt_kick_i (kick),
      .rst_o      (rsto0),
      .ready_o    (rdy0),
      .cause_o    (cause0)
   );

   rst_sequencer #(.NUM_CH(1)) dut1 (
      .clk_i      (clk),
      .rst_i      (rst),
      .swrst_req_i(req),
      .swrst_ack_o(ack1),
      .wdt_en_i   (en),
      .wdt_kick_i (kick),
      .rst_o      (rsto1),
      .ready_o    (rdy1),
      .cause_o    (cause1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int nch(input int b);
      return (b == 0) ? 3 : 1;
   endfunction

   function automatic int t_last(input int b);
      return HOLD + (nch(b) - 1) * STAG;
   endfunction

   function automatic logic [7:0] exp_rst(input int a, input int n);
      logic [7:0] v;
      v = '0;
      for (int k = 0; k < n; k++) v[k] = (a < HOLD + k * STAG);
      return v;
   endfunction

   task automatic chk(input string nm, input logic [7:0] got,
                      input logic [7:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, got, exp, cyc);
      end
   endtask

   // Timeline model advanced on every rising edge.
   always @(posedge clk) begin
      cyc++;
      for (int b = 0; b < 2; b++) begin
         mack[b] = 1'b0;
         if (rst) begin
            age[b]    = 0;
            wd[b]     = 0;
            mcause[b] = 2'b00;
         end else if (age[b] >= t_last(b)) begin
            if (en && !kick && wd[b] == WDT - 1) begin
               age[b]    = 0;
               wd[b]     = 0;
               mcause[b] = 2'b10;
            end else if (req) begin
               age[b]    = 0;
               wd[b]     = 0;
               mcause[b] = 2'b01;
               mack[b]   = 1'b1;
            end else begin
               wd[b] = (en && !kick) ? wd[b] + 1 : 0;
            end
         end else begin
            age[b] = age[b] + 1;
            wd[b]  = 0;
         end
      end
   end

   // Every-cycle comparison of both builds against the model.
   always @(negedge clk) begin
      if (cyc > 0) begin
         chk("m_rst0", {5'b0, rsto0}, exp_rst(age[0], 3));
         chk("m_rdy0", {7'b0, rdy0}, {7'b0, age[0] >= t_last(0)});
         chk("m_cause0", {6'b0, cause0}, {6'b0, mcause[0]});
         chk("m_ack0", {7'b0, ack0}, {7'b0, mack[0]});
         chk("m_rst1", {7'b0, rsto1}, exp_rst(age[1], 1));
         chk("m_rdy1", {7'b0, rdy1}, {7'b0, age[1] >= t_last(1)});
         chk("m_cause1", {6'b0, cause1}, {6'b0, mcause[1]});
         chk("m_ack1", {7'b0, ack1}, {7'b0, mack[1]});
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic lit(input string nm, input logic [2:0] r,
                      input logic rd, input logic [1:0] c, input logic a);
      chk({nm, "_rst"}, {5'b0, rsto0}, {5'b0, r});
      chk({nm, "_rdy"}, {7'b0, rdy0}, {7'b0, rd});
      chk({nm, "_cause"}, {6'b0, cause0}, {6'b0, c});
      chk({nm, "_ack"}, {7'b0, ack0}, {7'b0, a});
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      cyc         = 0;
      rst  = 1'b1;
      req  = 1'b0;
      en   = 1'b0;
      kick = 1'b0;
      step(2);
      lit("reset", 3'b111, 1'b0, 2'b00, 1'b0);
      rst = 1'b0;

      // Power-up release: 16 / 20 / 24 edges after rst_i drops.
      step(15);
      lit("por15", 3'b111, 1'b0, 2'b00, 1'b0);
      chk("ch1_rdy15", {7'b0, rdy1}, 8'h00);
      step(1);
      lit("por16", 3'b110, 1'b0, 2'b00, 1'b0);
      chk("ch1_rdy16", {7'b0, rdy1}, 8'h01);
      chk("ch1_rst16", {7'b0, rsto1}, 8'h00);
      step(4);
      lit("por20", 3'b100, 1'b0, 2'b00, 1'b0);
      step(4);
      lit("por24", 3'b000, 1'b1, 2'b00, 1'b0);

      // One-cycle software request in RUN.
      req = 1'b1;
      step(1);
      lit("sw_ack", 3'b111, 1'b0, 2'b01, 1'b1);
      req = 1'b0;
      step(1);
      lit("sw_ack_gone", 3'b111, 1'b0, 2'b01, 1'b0);
      step(15);
      lit("sw16", 3'b110, 1'b0, 2'b01, 1'b0);
      step(4);
      lit("sw20", 3'b100, 1'b0, 2'b01, 1'b0);
      step(4);
      lit("sw24", 3'b000, 1'b1, 2'b01, 1'b0);

      // Request held through STAGGER is only acked once RUN is reached.
      req = 1'b1;
      step(1);
      req = 1'b0;
      step(17);
      lit("stg17", 3'b110, 1'b0, 2'b01, 1'b0);
      req = 1'b1;
      step(1);
      lit("stg18", 3'b110, 1'b0, 2'b01, 1'b0);
      step(5);
      lit("stg23", 3'b100, 1'b0, 2'b01, 1'b0);
      step(1);
      lit("stg24", 3'b000, 1'b1, 2'b01, 1'b0);
      step(1);
      lit("stg_run_ack", 3'b111, 1'b0, 2'b01, 1'b1);
      req = 1'b0;
      step(30);

      // External reset in the middle of a sequence restarts it.
      req = 1'b1;
      step(1);
      req = 1'b0;
      step(18);
      lit("mid18", 3'b110, 1'b0, 2'b01, 1'b0);
      rst = 1'b1;
      step(1);
      lit("mid_rst", 3'b111, 1'b0, 2'b00, 1'b0);
      rst = 1'b0;
      step(15);
      lit("mid15", 3'b111, 1'b0, 2'b00, 1'b0);
      step(1);
      lit("mid16", 3'b110, 1'b0, 2'b00, 1'b0);
      step(8);
      lit("mid24", 3'b000, 1'b1, 2'b00, 1'b0);

      // Watchdog expiry on the 200th RUN edge without kicks.
      en = 1'b1;
      step(199);
      lit("wdt199", 3'b000, 1'b1, 2'b00, 1'b0);
      step(1);
      lit("wdt200", 3'b111, 1'b0, 2'b10, 1'b0);
      step(24);
      lit("wdt_rel", 3'b000, 1'b1, 2'b10, 1'b0);

      // Kicking every 100 cycles keeps RUN for 10000 cycles.
      for (int i = 0; i < 100; i++) begin
         step(99);
         kick = 1'b1;
         step(1);
         kick = 1'b0;
      end
      lit("kicked", 3'b000, 1'b1, 2'b10, 1'b0);

      // Watchdog expiry coinciding with a software request.
      step(199);
      lit("race199", 3'b000, 1'b1, 2'b10, 1'b0);
      req = 1'b1;
      step(1);
      lit("race", 3'b111, 1'b0, 2'b10, 1'b0);
      chk("race_ack1", {7'b0, ack1}, 8'h00);
      chk("race_cause1", {6'b0, cause1}, 8'h02);
      req = 1'b0;
      en  = 1'b0;
      step(30);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/rst_sequencer.md
RST_SEQUENCER -- requirements
Module: rst_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 3, meaning the number of sequenced reset outputs (legal range 1-8).
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 16, meaning cycles all outputs stay asserted before the first release (legal range 1 to 2^CNT_W-1).
REQ-003 The block SHALL have parameter STAGGER_CYCLES, default 4, meaning cycles between consecutive channel releases (legal range 1 to 2^CNT_W-1).
REQ-004 The block SHALL have parameter WDT_CYCLES, default 200, meaning the watchdog timeout in cycles (legal range 2 to 2^CNT_W-1).
REQ-005 The block SHALL have parameter CNT_W, default 8, meaning the width of the internal counters.
REQ-006 The block SHALL have port clk_i, input, 1 bit: the single clock, all logic on its rising edge.
REQ-007 The block SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port swrst_req_i, input, 1 bit: software reset request, level-sampled.
REQ-009 The block SHALL have port swrst_ack_o, output, 1 bit: one-cycle pulse acknowledging an accepted software request.
REQ-010 The block SHALL have port wdt_en_i, input, 1 bit: watchdog enable.
REQ-011 The block SHALL have port wdt_kick_i, input, 1 bit: watchdog restart.
REQ-012 The block SHALL have port rst_o, output, NUM_CH bits: active-high domain resets, channel 0 released first.
REQ-013 The block SHALL have port ready_o, output, 1 bit: high when all channels are released.
REQ-014 The block SHALL have port cause_o, output, 2 bits: last reset cause (00 external, 01 software, 10 watchdog, 11 unused).

Function
REQ-015 The state machine SHALL have exactly three states: HOLD, STAGGER and RUN.
REQ-016 In HOLD, all rst_o bits SHALL be 1, and a counter SHALL count from 0 up to HOLD_CYCLES-1.
REQ-017 On the edge where the HOLD counter equals HOLD_CYCLES-1, the block SHALL clear rst_o[0] and move to STAGGER, or to RUN if NUM_CH=1.
REQ-018 In STAGGER, rst_o[k] SHALL clear STAGGER_CYCLES edges after rst_o[k-1] clears.
REQ-019 When rst_o[NUM_CH-1] clears, the block SHALL set ready_o on the same edge and move to RUN.
REQ-020 Once cleared, an rst_o bit SHALL stay 0 until the next entry to HOLD.
REQ-021 From the first edge with rst_i low, rst_o[k] SHALL fall exactly HOLD_CYCLES + k*STAGGER_CYCLES edges later.
REQ-022 In RUN with swrst_req_i=1, the block SHALL pulse swrst_ack_o for one cycle, set cause_o=01, set rst_o all-ones, clear ready_o, and enter HOLD with the counter at 0, all on the same edge.
REQ-023 swrst_req_i SHALL be ignored, with no ack, in HOLD and STAGGER.
REQ-024 A request still held high when the block re-enters RUN SHALL be accepted again, which makes requests level-sensitive.
REQ-025 The watchdog counter SHALL advance only in RUN with wdt_en_i=1.
REQ-026 The watchdog counter SHALL clear when wdt_kick_i=1, when wdt_en_i=0, or outside RUN; kick SHALL have priority over increment.
REQ-027 When the watchdog counter equals WDT_CYCLES-1 with no kick, the block SHALL enter HOLD with cause_o=10 on that edge.
REQ-028 If watchdog expiry and a software request occur on the same edge, the watchdog SHALL win: cause_o=10 and swrst_ack_o stays 0.
REQ-029 Counter arithmetic SHALL be unsigned CNT_W-bit, with no wrap inside legal parameter ranges.
REQ-030 Parameter violations SHALL be flagged by a simulation-time check that is not synthesised.

Reset
REQ-031 While rst_i=1, on every edge the block SHALL force state=HOLD, counter=0, watchdog=0, rst_o all-ones, ready_o=0, swrst_ack_o=0 and cause_o=00.
REQ-032 rst_i SHALL take priority over every other input, in any state.
REQ-033 rst_i asserted mid-sequence SHALL restart the full sequence, and the release timing of REQ-021 SHALL be measured from rst_i deassertion.

Verification
REQ-034 The bench SHALL cover, with defaults: rst_i high 2 cycles then low -> rst_o 111 for 16 edges, then 110 at edge 16, 100 at 20, 000 at 24; ready_o=1 at 24; cause_o=00.
REQ-035 The bench SHALL cover: swrst_req_i pulsed 1 cycle in RUN -> swrst_ack_o for 1 cycle, rst_o=111, cause_o=01, release repeats 16/20/24 edges later.
REQ-036 The bench SHALL cover: wdt_en_i=1 with no kick -> 200th RUN edge enters HOLD with cause_o=10; kicking every 100 cycles keeps the block in RUN for 10000 cycles.
REQ-037 The bench SHALL cover: swrst_req_i held high during STAGGER -> no ack until RUN, then ack on the first RUN edge and a second full sequence.
REQ-038 The bench SHALL cover: rst_i pulsed at edge 18 of a sequence (rst_o=110) -> rst_o=111 and cause_o=00 immediately, then rst_o[0] falls 16 edges after rst_i drops.
REQ-039 The bench SHALL cover: watchdog expiry coinciding with swrst_req_i -> cause_o=10, swrst_ack_o=0; the NUM_CH=1 build shows ready_o at edge 16.
